read_buffer_pl: RTL and testbench
=================================

# read_buffer_pl

Read-side counterpart of the write buffer on the CCI-E link. Accepts 32-bit word reads (or full-line direct reads) from the accelerator pipeline, serves them from a single-line buffer on a hit, and on a miss issues one cache-line read request, matches the response by mdata tag, refills the buffer and returns the selected word. Sits between the accelerator datapath and the QPI/CCI read request/response channels, alongside the write buffer.

## Interface
- ADDR_LMT, 20, cache-line address width
- MDATA, 14, request/response tag width
- CACHE_WIDTH, 512, line width in bits
- DATA_WIDTH, 32, word width

- clk  input  1  clock; all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- rd_req_addr  output  ADDR_LMT  line address of read request
- rd_req_mdata  output  MDATA  request tag
- rd_req_en  output  1  read request strobe, one cycle per request
- rd_req_almostfull  input  1  request channel cannot accept
- rd_rsp_valid  input  1  read response strobe
- rd_rsp_mdata  input  MDATA  response tag
- rd_rsp_data  input  CACHE_WIDTH  response line
- rd_en  input  1  accelerator read strobe
- rd_addr  input  ADDR_LMT+4  word address: [ADDR_LMT+3:4] line, [3:0] word offset
- rd_direct  input  1  qualifies rd_en: full-line read, bypasses buffer
- inv_en  input  1  invalidate strobe (write to a line)
- inv_addr  input  ADDR_LMT  line to invalidate
- rd_busy  output  1  miss in progress; rd_en not accepted
- rd_valid  output  1  one-cycle result strobe
- rd_data  output  DATA_WIDTH  selected word
- rd_line  output  CACHE_WIDTH  full line (valid with rd_valid on direct reads, else last line)
- rd_err  output  1  one-cycle pulse: rd_en while busy

## Operation
- State: buf_line, buf_tag (ADDR_LMT), buf_vld, FSM {IDLE, REQ, WAIT}, pend_addr, pend_off, pend_direct, seq counter (MDATA-1 bits).
- IDLE, rd_en, !rd_direct, buf_vld && buf_tag==line: hit; rd_valid=1, rd_data=buf_line[off*32 +: 32] next cycle.
- IDLE, rd_en, miss or rd_direct: latch line/offset/direct, go REQ.
- REQ: while rd_req_almostfull stay (rd_req_en=0). Else rd_req_en=1 next cycle with rd_req_addr=pend_addr, rd_req_mdata={1'b1, seq}; go WAIT.
- WAIT: only rd_rsp_valid with rd_rsp_mdata=={1'b1, seq} accepted; all other responses ignored. On match: rd_valid=1, rd_data=rsp word at pend_off, rd_line=rd_rsp_data; if !pend_direct load buf_line/buf_tag, buf_vld=1; seq increments (wraps 2^(MDATA-1)-1 -> 0); go IDLE.
- rd_busy = (state != IDLE). rd_en while busy: dropped, rd_err pulses next cycle.
- Invalidate: inv_en && buf_tag==inv_addr clears buf_vld. Same-cycle inv_en and fill of the same line: invalidate wins (buf_vld=0), data still returned to requester. Same-cycle inv_en and hit in IDLE: hit still served from old data, buf_vld cleared.
- Direct reads never modify buffer contents.

## Timing
- Reset (rst low, async): state IDLE, buf_vld=0, seq=0, rd_req_en=0, rd_req_addr=0, rd_req_mdata=0, rd_valid=0, rd_data=0, rd_line=0, rd_err=0, rd_busy=0.
- Hit latency: rd_en at t -> rd_valid at t+1.
- Miss: rd_en at t -> REQ at t+1 -> rd_req_en at t+2 if almostfull low at t+1; each almostfull cycle adds one.
- Response accepted at r -> rd_valid at r+1, state IDLE at r+1, new rd_en accepted at r+1.
- rd_req_en, rd_valid, rd_err: single-cycle pulses; payloads return to 0 when strobe low except rd_line/rd_data (hold).
- Reset asserted mid-miss: FSM to IDLE, outstanding response later ignored (seq reset, tag mismatch not guaranteed — upper tag bit plus state WAIT required to accept).

## Structure
- Shared package: FSM state encoding, tag marker bit position, word-select helper constant (WORDS_PER_LINE=16).
- One sub-module natural: line_word_sel (CACHE_WIDTH line, 4-bit offset -> DATA_WIDTH word), reused for hit and response paths.

## Test plan
- Cold read rd_addr=0x35 (line 3, word 5); respond tag {1,0} with word5=0xDEADBEEF -> rd_req_addr=3, rd_valid one cycle after response, rd_data=0xDEADBEEF.
- Follow-up rd_addr=0x3F -> no request, rd_valid at t+1 with word 15 of buffered line.
- rd_req_almostfull held 5 cycles during REQ -> rd_req_en delayed exactly 5 cycles, fires once.
- WAIT with foreign response tag 0x0005 then correct tag -> foreign ignored, data from correct response, seq now 1.
- inv_en line 3 same cycle as fill of line 3 -> rd_valid with data, next read of line 3 issues new request.
- rd_en during WAIT -> rd_err pulse, no second request; rst low mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/read_buffer_pl_pkg.sv
// Shared widths, FSM encoding and tag helper for the single-line read buffer.
package read_buffer_pl_pkg;

    localparam int ADDR_LMT       = 20;
    localparam int MDATA          = 14;
    localparam int CACHE_WIDTH    = 512;
    localparam int DATA_WIDTH     = 32;
    localparam int WORDS_PER_LINE = 16;
    localparam int OFF_W          = 4;
    localparam int SEQ_W          = MDATA - 1;
    localparam int TAG_MARK_BIT   = MDATA - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Own requests always carry the marker bit so untagged traffic can never match.
    function automatic logic [MDATA-1:0] make_tag(input logic [SEQ_W-1:0] seq);
        logic [MDATA-1:0] tag;
        tag                  = '0;
        tag[SEQ_W-1:0]       = seq;
        tag[TAG_MARK_BIT]    = 1'b1;
        return tag;
    endfunction

endpackage

// File: rtl/read_buffer_pl_if.sv
// Request/response channels plus accelerator-side read port of the read buffer.
interface read_buffer_pl_if;
    import read_buffer_pl_pkg::*;

    logic [ADDR_LMT-1:0]       rd_req_addr;
    logic [MDATA-1:0]          rd_req_mdata;
    logic                      rd_req_en;
    logic                      rd_req_almostfull;
    logic                      rd_rsp_valid;
    logic [MDATA-1:0]          rd_rsp_mdata;
    logic [CACHE_WIDTH-1:0]    rd_rsp_data;
    logic                      rd_en;
    logic [ADDR_LMT+OFF_W-1:0] rd_addr;
    logic                      rd_direct;
    logic                      inv_en;
    logic [ADDR_LMT-1:0]       inv_addr;
    logic                      rd_busy;
    logic                      rd_valid;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic [CACHE_WIDTH-1:0]    rd_line;
    logic                      rd_err;

    modport slave (
        output rd_req_addr, rd_req_mdata, rd_req_en,
        input  rd_req_almostfull,
        input  rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
        input  rd_en, rd_addr, rd_direct, inv_en, inv_addr,
        output rd_busy, rd_valid, rd_data, rd_line, rd_err
    );

    modport master (
        input  rd_req_addr, rd_req_mdata, rd_req_en,
        output rd_req_almostfull,
        output rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
        output rd_en, rd_addr, rd_direct, inv_en, inv_addr,
        input  rd_busy, rd_valid, rd_data, rd_line, rd_err
    );

endinterface

// File: rtl/read_buffer_pl_line_word_sel.sv
// Picks one DATA_WIDTH word out of a cache line by 4-bit word offset.
module line_word_sel
    import read_buffer_pl_pkg::*;
(
    input  logic [CACHE_WIDTH-1:0] line_i,
    input  logic [OFF_W-1:0]       off_i,
    output logic [DATA_WIDTH-1:0]  word_o
);

    logic [DATA_WIDTH-1:0] words [WORDS_PER_LINE];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
            assign words[gi] = line_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign word_o = words[off_i];

endmodule

// File: rtl/read_buffer_pl.sv
// Single-line read buffer: serves word hits locally, fetches a line on miss or
// direct read, and matches the response by its sequence tag.
module read_buffer_pl
    import read_buffer_pl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    read_buffer_pl_if.slave bus
);

    state_e                 state_q, state_d;
    logic [CACHE_WIDTH-1:0] buf_line_q, buf_line_d;
    logic [ADDR_LMT-1:0]    buf_tag_q, buf_tag_d;
    logic                   buf_vld_q, buf_vld_d;
    logic [ADDR_LMT-1:0]    pend_addr_q, pend_addr_d;
    logic [OFF_W-1:0]       pend_off_q, pend_off_d;
    logic                   pend_direct_q, pend_direct_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;

    logic [ADDR_LMT-1:0]    req_addr_q, req_addr_d;
    logic [MDATA-1:0]       req_mdata_q, req_mdata_d;
    logic                   req_en_q, req_en_d;
    logic                   valid_q, valid_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [CACHE_WIDTH-1:0] line_q, line_d;
    logic                   err_q, err_d;

    logic [ADDR_LMT-1:0]    rd_line_addr;
    logic [OFF_W-1:0]       rd_off;
    logic [DATA_WIDTH-1:0]  hit_word;
    logic [DATA_WIDTH-1:0]  rsp_word;
    logic                   hit;
    logic                   rsp_match;

    assign rd_line_addr = bus.rd_addr[ADDR_LMT+OFF_W-1:OFF_W];
    assign rd_off       = bus.rd_addr[OFF_W-1:0];

    line_word_sel u_hit_sel (
        .line_i (buf_line_q),
        .off_i  (rd_off),
        .word_o (hit_word)
    );

    line_word_sel u_rsp_sel (
        .line_i (bus.rd_rsp_data),
        .off_i  (pend_off_q),
        .word_o (rsp_word)
    );

    assign hit       = !bus.rd_direct && buf_vld_q && (buf_tag_q == rd_line_addr);
    assign rsp_match = bus.rd_rsp_valid && (bus.rd_rsp_mdata == make_tag(seq_q));

    always_comb begin
        state_d       = state_q;
        buf_line_d    = buf_line_q;
        buf_tag_d     = buf_tag_q;
        buf_vld_d     = buf_vld_q;
        pend_addr_d   = pend_addr_q;
        pend_off_d    = pend_off_q;
        pend_direct_d = pend_direct_q;
        seq_d         = seq_q;
        req_en_d      = 1'b0;
        req_addr_d    = '0;
        req_mdata_d   = '0;
        valid_d       = 1'b0;
        data_d        = data_q;
        line_d        = line_q;
        err_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.rd_en) begin
                    if (hit) begin
                        valid_d = 1'b1;
                        data_d  = hit_word;
                    end else begin
                        pend_addr_d   = rd_line_addr;
                        pend_off_d    = rd_off;
                        pend_direct_d = bus.rd_direct;
                        state_d       = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                err_d = bus.rd_en;
                if (!bus.rd_req_almostfull) begin
                    req_en_d    = 1'b1;
                    req_addr_d  = pend_addr_q;
                    req_mdata_d = make_tag(seq_q);
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                err_d = bus.rd_en;
                if (rsp_match) begin
                    valid_d = 1'b1;
                    data_d  = rsp_word;
                    line_d  = bus.rd_rsp_data;
                    // Direct reads hand the line back but leave the buffer untouched.
                    if (!pend_direct_q) begin
                        buf_line_d = bus.rd_rsp_data;
                        buf_tag_d  = pend_addr_q;
                        buf_vld_d  = 1'b1;
                    end
                    seq_d   = seq_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Checked against the post-fill tag so a same-cycle write to the filled line wins.
        if (bus.inv_en && (buf_tag_d == bus.inv_addr)) begin
            buf_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            buf_line_q    <= '0;
            buf_tag_q     <= '0;
            buf_vld_q     <= 1'b0;
            pend_addr_q   <= '0;
            pend_off_q    <= '0;
            pend_direct_q <= 1'b0;
            seq_q         <= '0;
            req_addr_q    <= '0;
            req_mdata_q   <= '0;
            req_en_q      <= 1'b0;
            valid_q       <= 1'b0;
            data_q        <= '0;
            line_q        <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_line_q    <= buf_line_d;
            buf_tag_q     <= buf_tag_d;
            buf_vld_q     <= buf_vld_d;
            pend_addr_q   <= pend_addr_d;
            pend_off_q    <= pend_off_d;
            pend_direct_q <= pend_direct_d;
            seq_q         <= seq_d;
            req_addr_q    <= req_addr_d;
            req_mdata_q   <= req_mdata_d;
            req_en_q      <= req_en_d;
            valid_q       <= valid_d;
            data_q        <= data_d;
            line_q        <= line_d;
            err_q         <= err_d;
        end
    end

    assign bus.rd_req_addr  = req_addr_q;
    assign bus.rd_req_mdata = req_mdata_q;
    assign bus.rd_req_en    = req_en_q;
    assign bus.rd_busy      = (state_q != ST_IDLE);
    assign bus.rd_valid     = valid_q;
    assign bus.rd_data      = data_q;
    assign bus.rd_line      = line_q;
    assign bus.rd_err       = err_q;

endmodule

// File: tb/tb_read_buffer_pl.sv
// Directed plus randomized bench for read_buffer_pl against a word-array model.
`define CHK(tag, obs, exp) check(tag, 512'(obs), 512'(exp))

module tb_read_buffer_pl;
    import read_buffer_pl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    read_buffer_pl_if bus();

    read_buffer_pl dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: one buffered line held as 16 words, plus the next request sequence number.
    logic        mdl_vld;
    logic [19:0] mdl_tag;
    logic [31:0] mdl_words [16];
    logic [12:0] mdl_seq;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_inv(input logic [19:0] inv_line);
        if (mdl_tag == inv_line) mdl_vld = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        `CHK({tag, "_req_en"},    bus.rd_req_en,    1'b0);
        `CHK({tag, "_req_addr"},  bus.rd_req_addr,  20'h0);
        `CHK({tag, "_req_mdata"}, bus.rd_req_mdata, 14'h0);
        `CHK({tag, "_valid"},     bus.rd_valid,     1'b0);
        `CHK({tag, "_data"},      bus.rd_data,      32'h0);
        `CHK({tag, "_line"},      bus.rd_line,      512'h0);
        `CHK({tag, "_err"},       bus.rd_err,       1'b0);
        `CHK({tag, "_busy"},      bus.rd_busy,      1'b0);
    endtask

    task automatic hit_read(input logic [23:0] addr, input bit inv, input logic [19:0] inv_line);
        logic [3:0] off;
        off = addr[3:0];
        bus.rd_en = 1'b1; bus.rd_addr = addr; bus.rd_direct = 1'b0;
        bus.inv_en = inv; bus.inv_addr = inv_line;
        tick();
        bus.rd_en = 1'b0; bus.inv_en = 1'b0;
        `CHK("hit_valid",  bus.rd_valid,  1'b1);
        `CHK("hit_data",   bus.rd_data,   mdl_words[off]);
        `CHK("hit_no_req", bus.rd_req_en, 1'b0);
        `CHK("hit_busy",   bus.rd_busy,   1'b0);
        if (inv) apply_inv(inv_line);
        tick();
        `CHK("hit_valid_end", bus.rd_valid, 1'b0);
        `CHK("hit_data_hold", bus.rd_data,  mdl_words[off]);
        $display("hit  addr=%06h data=%08h", addr, mdl_words[off]);
    endtask

    task automatic miss_read(input logic [23:0] addr, input bit direct, input int af_cycles,
                             input int n_foreign, input bit err_in_wait, input bit inv_at_fill,
                             input logic [19:0] inv_line, input bit force_dead);
        logic [19:0]  line;
        logic [3:0]   off;
        logic [31:0]  words [16];
        logic [511:0] packed_line;
        logic [13:0]  ft;
        line = addr[23:4];
        off  = addr[3:0];
        for (int i = 0; i < 16; i++) words[i] = $urandom;
        if (force_dead) words[off] = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) packed_line[i*32 +: 32] = words[i];

        bus.rd_req_almostfull = (af_cycles > 0);
        bus.rd_en = 1'b1; bus.rd_addr = addr; bus.rd_direct = direct;
        tick();
        bus.rd_en = 1'b0; bus.rd_direct = 1'b0;
        `CHK("miss_busy",     bus.rd_busy,   1'b1);
        `CHK("miss_no_valid", bus.rd_valid,  1'b0);
        `CHK("miss_no_req",   bus.rd_req_en, 1'b0);
        for (int k = 0; k < af_cycles; k++) begin
            tick();
            `CHK("af_hold_req", bus.rd_req_en, 1'b0);
        end
        bus.rd_req_almostfull = 1'b0;
        tick();
        `CHK("req_en",    bus.rd_req_en,    1'b1);
        `CHK("req_addr",  bus.rd_req_addr,  line);
        `CHK("req_mdata", bus.rd_req_mdata, {1'b1, mdl_seq});

        if (err_in_wait) begin
            bus.rd_en = 1'b1; bus.rd_addr = 24'($urandom); bus.rd_direct = 1'($urandom_range(0, 1));
            tick();
            bus.rd_en = 1'b0; bus.rd_direct = 1'b0;
            `CHK("err_pulse", bus.rd_err, 1'b1);
        end else begin
            tick();
        end
        `CHK("req_pulse_end",  bus.rd_req_en,    1'b0);
        `CHK("req_mdata_zero", bus.rd_req_mdata, 14'h0);
        `CHK("wait_busy",      bus.rd_busy,      1'b1);
        if (err_in_wait) begin
            tick();
            `CHK("err_pulse_end", bus.rd_err,    1'b0);
            `CHK("err_no_req",    bus.rd_req_en, 1'b0);
        end

        for (int f = 0; f < n_foreign; f++) begin
            ft = (f == 0) ? 14'h0005 : 14'($urandom);
            if (ft == {1'b1, mdl_seq}) ft = ft ^ 14'h1;
            bus.rd_rsp_valid = 1'b1; bus.rd_rsp_mdata = ft; bus.rd_rsp_data = {16{$urandom}};
            tick();
            bus.rd_rsp_valid = 1'b0;
            `CHK("foreign_ignored", bus.rd_valid, 1'b0);
            `CHK("foreign_busy",    bus.rd_busy,  1'b1);
        end

        bus.rd_rsp_valid = 1'b1; bus.rd_rsp_mdata = {1'b1, mdl_seq}; bus.rd_rsp_data = packed_line;
        bus.inv_en = inv_at_fill; bus.inv_addr = inv_line;
        tick();
        bus.rd_rsp_valid = 1'b0; bus.inv_en = 1'b0;
        `CHK("rsp_valid", bus.rd_valid, 1'b1);
        `CHK("rsp_data",  bus.rd_data,  words[off]);
        `CHK("rsp_line",  bus.rd_line,  packed_line);
        `CHK("rsp_idle",  bus.rd_busy,  1'b0);

        if (!direct) begin
            mdl_vld = 1'b1;
            mdl_tag = line;
            for (int i = 0; i < 16; i++) mdl_words[i] = words[i];
        end
        if (inv_at_fill) apply_inv(inv_line);
        mdl_seq = mdl_seq + 13'd1;

        tick();
        `CHK("rsp_valid_end", bus.rd_valid, 1'b0);
        $display("miss addr=%06h direct=%0d af=%0d foreign=%0d data=%08h", addr, direct, af_cycles, n_foreign, words[off]);
    endtask

    initial begin
        logic [23:0] a;
        logic        dir;
        rst_n = 1'b0;
        bus.rd_req_almostfull = 1'b0; bus.rd_rsp_valid = 1'b0; bus.rd_rsp_mdata = '0;
        bus.rd_rsp_data = '0; bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_direct = 1'b0;
        bus.inv_en = 1'b0; bus.inv_addr = '0;
        mdl_vld = 1'b0; mdl_tag = '0; mdl_seq = '0;
        for (int i = 0; i < 16; i++) mdl_words[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        miss_read(24'h000035, 1'b0, 0, 0, 1'b0, 1'b0, 20'h0, 1'b1);
        checks++;
        if (bus.rd_data !== 32'hDEADBEEF) begin
            errors++;
            $error("FAIL cold_deadbeef observed=%0h expected=deadbeef", bus.rd_data);
        end
        hit_read(24'h00003F, 1'b0, 20'h0);
        miss_read(24'h00007A, 1'b0, 5, 0, 1'b0, 1'b0, 20'h0, 1'b0);
        miss_read(24'h00004C, 1'b0, 0, 2, 1'b0, 1'b0, 20'h0, 1'b0);
        miss_read(24'h000032, 1'b0, 0, 0, 1'b0, 1'b1, 20'h3, 1'b0);
        miss_read(24'h000031, 1'b0, 0, 0, 1'b0, 1'b0, 20'h0, 1'b0);
        miss_read(24'h000058, 1'b0, 1, 0, 1'b1, 1'b0, 20'h0, 1'b0);
        miss_read(24'h000036, 1'b1, 0, 0, 1'b0, 1'b0, 20'h0, 1'b0);
        miss_read(24'h000036, 1'b0, 0, 0, 1'b0, 1'b0, 20'h0, 1'b0);
        miss_read(24'h000036, 1'b1, 0, 1, 1'b0, 1'b0, 20'h0, 1'b0);
        hit_read(24'h000037, 1'b1, 20'h3);
        miss_read(24'h000037, 1'b0, 0, 0, 1'b0, 1'b0, 20'h0, 1'b0);

        // Reset in the middle of an outstanding miss, then replay its response.
        bus.rd_en = 1'b1; bus.rd_addr = 24'h000090; bus.rd_direct = 1'b0;
        tick();
        bus.rd_en = 1'b0;
        tick();
        checks++;
        if (bus.rd_req_en !== 1'b1) begin
            errors++;
            $error("FAIL rstw_req_en observed=%0h expected=1", bus.rd_req_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid_wait");
        @(negedge clk);
        rst_n = 1'b1;
        bus.rd_rsp_valid = 1'b1; bus.rd_rsp_mdata = {1'b1, mdl_seq}; bus.rd_rsp_data = {16{$urandom}};
        mdl_vld = 1'b0; mdl_seq = '0;
        @(posedge clk);
        #1;
        bus.rd_rsp_valid = 1'b0;
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $error("FAIL stale_rsp_ignored observed=%0h expected=0", bus.rd_valid);
        end
        checks++;
        if (bus.rd_busy !== 1'b0) begin
            errors++;
            $error("FAIL stale_rsp_idle observed=%0h expected=0", bus.rd_busy);
        end
        $display("reset mid-wait: outputs cleared, stale response dropped");
        miss_read(24'h000031, 1'b0, 0, 0, 1'b0, 1'b0, 20'h0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            a   = {20'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            dir = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) begin
                bus.inv_en = 1'b1; bus.inv_addr = 20'($urandom_range(0, 3));
                tick();
                bus.inv_en = 1'b0;
                apply_inv(bus.inv_addr);
                $display("inv  line=%05h", bus.inv_addr);
            end
            if (!dir && mdl_vld && mdl_tag == a[23:4])
                hit_read(a, 1'($urandom_range(0, 1)), 20'($urandom_range(0, 3)));
            else
                miss_read(a, dir, $urandom_range(0, 2), $urandom_range(0, 2),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          20'($urandom_range(0, 3)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
